// File: rtl/seat_write_arbiter.sv
// Command-port arbiter for the seating system: fixed-priority configuration
// requester plus round-robin kiosks, one registered pulse followed by a gap cycle.
module seat_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LIMIT_RST = 10,
  parameter int BAN_RST   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_student,
  input  logic [5*NUM_REQ-1:0]   req_seat,
  input  logic [2*NUM_REQ-1:0]   req_state,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rej,
  input  logic                   cfg_req,
  input  logic [1:0]             cfg_sel,
  input  logic [1:0]             cfg_ban,
  input  logic [10:0]            cfg_limit,
  output logic                   cfg_ack,
  output logic                   write,
  output logic [31:0]            Student_No,
  output logic [4:0]             Seat_No,
  output logic [1:0]             Seat_State,
  output logic [1:0]             write_set,
  output logic [1:0]             ban,
  output logic [10:0]            limit_time,
  output logic                   busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 rej_q, rej_d;
  logic                 cfg_ack_q, cfg_ack_d;
  logic                 write_q, write_d;
  logic [1:0]           write_set_q, write_set_d;
  logic [31:0]          student_q, student_d;
  logic [4:0]           seat_q, seat_d;
  logic [1:0]           seat_state_q, seat_state_d;
  logic [1:0]           ban_q, ban_d;
  logic [10:0]          limit_q, limit_d;
  logic                 busy_q, busy_d;

  logic                 win_valid;
  logic [PW-1:0]        win_idx;
  logic [1:0]           win_state;
  int                   scan_idx;

  // Round-robin scan: first asserted request at or after ptr, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = PW'(scan_idx);
      end
    end
  end

  assign win_state = req_state[int'(win_idx)*2 +: 2];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    rej_d        = 1'b0;
    cfg_ack_d    = 1'b0;
    write_d      = 1'b0;
    write_set_d  = 2'd0;
    student_d    = student_q;
    seat_d       = seat_q;
    seat_state_d = seat_state_q;
    ban_d        = ban_q;
    limit_d      = limit_q;

    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          state_d   = ISSUE;
          cfg_ack_d = 1'b1;
          case (cfg_sel)
            2'd1: begin
              write_set_d = 2'd1;
              ban_d       = cfg_ban;
            end
            2'd2: begin
              write_set_d = 2'd2;
              limit_d     = cfg_limit;
            end
            default: ;
          endcase
        end else if (win_valid) begin
          state_d        = ISSUE;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          // State 3 is not a legal seat state: accept and reject without a write.
          if (win_state == 2'd3) begin
            rej_d = 1'b1;
          end else begin
            write_d      = 1'b1;
            student_d    = req_student[int'(win_idx)*32 +: 32];
            seat_d       = req_seat[int'(win_idx)*5 +: 5];
            seat_state_d = win_state;
          end
        end
      end
      ISSUE:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      rej_q        <= 1'b0;
      cfg_ack_q    <= 1'b0;
      write_q      <= 1'b0;
      write_set_q  <= 2'd0;
      student_q    <= '0;
      seat_q       <= '0;
      seat_state_q <= '0;
      ban_q        <= 2'(BAN_RST);
      limit_q      <= 11'(LIMIT_RST);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      rej_q        <= rej_d;
      cfg_ack_q    <= cfg_ack_d;
      write_q      <= write_d;
      write_set_q  <= write_set_d;
      student_q    <= student_d;
      seat_q       <= seat_d;
      seat_state_q <= seat_state_d;
      ban_q        <= ban_d;
      limit_q      <= limit_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rej        = rej_q;
  assign cfg_ack    = cfg_ack_q;
  assign write      = write_q;
  assign write_set  = write_set_q;
  assign Student_No = student_q;
  assign Seat_No    = seat_q;
  assign Seat_State = seat_state_q;
  assign ban        = ban_q;
  assign limit_time = limit_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seat_write_arbiter.sv
// Scoreboard bench for seat_write_arbiter: expected pulses are queued as
// stimulus is driven and matched against every pulse the arbiter produces.
module tb_seat_write_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_student = '0;
  logic [5*N-1:0]  req_seat = '0;
  logic [2*N-1:0]  req_state = '0;
  logic [N-1:0]    gnt;
  logic            rej;
  logic            cfg_req = 1'b0;
  logic [1:0]      cfg_sel = '0;
  logic [1:0]      cfg_ban = '0;
  logic [10:0]     cfg_limit = '0;
  logic            cfg_ack;
  logic            write;
  logic [31:0]     Student_No;
  logic [4:0]      Seat_No;
  logic [1:0]      Seat_State;
  logic [1:0]      write_set;
  logic [1:0]      ban;
  logic [10:0]     limit_time;
  logic            busy;

  seat_write_arbiter #(.NUM_REQ(N), .LIMIT_RST(10), .BAN_RST(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_student(req_student),
    .req_seat(req_seat), .req_state(req_state), .gnt(gnt), .rej(rej),
    .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_ban(cfg_ban),
    .cfg_limit(cfg_limit), .cfg_ack(cfg_ack), .write(write),
    .Student_No(Student_No), .Seat_No(Seat_No), .Seat_State(Seat_State),
    .write_set(write_set), .ban(ban), .limit_time(limit_time), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         rej;
    logic         wr;
    logic [1:0]   ws;
    logic         ack;
    logic [31:0]  stu;
    logic [4:0]   seat;
    logic [1:0]   st;
    logic [1:0]   ban;
    logic [10:0]  lim;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse = -100;

  // Reference model of the held output registers.
  logic [31:0] m_stu = '0;
  logic [4:0]  m_seat = '0;
  logic [1:0]  m_st = '0;
  logic [1:0]  m_ban = 2'd2;
  logic [10:0] m_lim = 11'd10;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_pulse = -100;
    end else if (write || rej || cfg_ack || (gnt != '0) || (write_set != 2'd0)) begin
      $display("TXN cyc=%0d gnt=%b rej=%b write=%b write_set=%0d ack=%b stu=%0d seat=%0d st=%0d ban=%0d lim=%0d",
               cyc, gnt, rej, write, write_set, cfg_ack, Student_No, Seat_No, Seat_State, ban, limit_time);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got gnt=%b write=%b write_set=%0d ack=%b, required no pulse",
                 gnt, write, write_set, cfg_ack);
      end else begin
        e = sb.pop_front();
        if ({gnt, rej, write, write_set, cfg_ack, Student_No, Seat_No, Seat_State, ban, limit_time} !==
            {e.gnt, e.rej, e.wr, e.ws, e.ack, e.stu, e.seat, e.st, e.ban, e.lim}) begin
          errors++;
          $display("FAIL pulse_contents: got gnt=%b rej=%b wr=%b ws=%0d ack=%b stu=%0d seat=%0d st=%0d ban=%0d lim=%0d, required gnt=%b rej=%b wr=%b ws=%0d ack=%b stu=%0d seat=%0d st=%0d ban=%0d lim=%0d",
                   gnt, rej, write, write_set, cfg_ack, Student_No, Seat_No, Seat_State, ban, limit_time,
                   e.gnt, e.rej, e.wr, e.ws, e.ack, e.stu, e.seat, e.st, e.ban, e.lim);
        end
      end
      if (last_pulse >= 0) begin
        checks++;
        if (cyc - last_pulse < 3) begin
          errors++;
          $display("FAIL pulse_gap: got %0d cycles, required at least 3", cyc - last_pulse);
        end
      end
      last_pulse = cyc;
    end
  end

  task automatic push_kiosk(input int k, input logic [31:0] s, input logic [4:0] se, input logic [1:0] st);
    exp_t e;
    e.gnt = '0;
    e.gnt[k] = 1'b1;
    e.rej = (st == 2'd3);
    e.wr  = (st != 2'd3);
    e.ws  = 2'd0;
    e.ack = 1'b0;
    if (st != 2'd3) begin
      m_stu = s; m_seat = se; m_st = st;
    end
    e.stu = m_stu; e.seat = m_seat; e.st = m_st; e.ban = m_ban; e.lim = m_lim;
    sb.push_back(e);
  endtask

  task automatic push_cfg(input logic [1:0] sel, input logic [1:0] b, input logic [10:0] l);
    exp_t e;
    e.gnt = '0; e.rej = 1'b0; e.wr = 1'b0; e.ack = 1'b1; e.ws = 2'd0;
    if (sel == 2'd1) begin e.ws = 2'd1; m_ban = b; end
    if (sel == 2'd2) begin e.ws = 2'd2; m_lim = l; end
    e.stu = m_stu; e.seat = m_seat; e.st = m_st; e.ban = m_ban; e.lim = m_lim;
    sb.push_back(e);
  endtask

  task automatic drive_kiosk(input int k, input logic [31:0] s, input logic [4:0] se, input logic [1:0] st);
    req_student[k*32 +: 32] = s;
    req_seat[k*5 +: 5]      = se;
    req_state[k*2 +: 2]     = st;
    req[k]                  = 1'b1;
  endtask

  // Waits (bounded) for gnt[k]; k < 0 waits for cfg_ack instead.
  task automatic wait_pulse(input int k, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((k < 0) ? cfg_ack : gnt[k]) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({write, write_set, gnt, rej, cfg_ack, busy, Student_No, Seat_No, Seat_State, ban, limit_time} !==
        {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 2'd2, 11'd10}) begin
      errors++;
      $display("FAIL reset_state: got wr=%b ws=%0d gnt=%b rej=%b ack=%b busy=%b stu=%0d seat=%0d st=%0d ban=%0d lim=%0d, required zeros ban=2 lim=10",
               write, write_set, gnt, rej, cfg_ack, busy, Student_No, Seat_No, Seat_State, ban, limit_time);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b gnt=%b, required 0 0000", busy, gnt);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int at;
    int prev;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) drive_kiosk(k, 32'd1000 + 32'(k), 5'(k + 3), 2'(k % 3));
    for (int j = 0; j < 5; j++) push_kiosk(order[j], 32'd1000 + 32'(order[j]), 5'(order[j] + 3), 2'(order[j] % 3));
    prev = -1;
    for (int j = 0; j < 5; j++) begin
      wait_pulse(order[j], ok, at);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_grant_%0d: got no grant to kiosk %0d, required grant within 20 cycles", j, order[j]);
      end else if (prev >= 0) begin
        checks++;
        if (at - prev != 3) begin
          errors++;
          $display("FAIL rr_spacing_%0d: got %0d cycles, required 3", j, at - prev);
        end
      end
      prev = at;
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    int at;
    drive_kiosk(0, 32'd201819186, 5'd1, 2'd2);
    push_kiosk(0, 32'd201819186, 5'd1, 2'd2);
    wait_pulse(0, ok, at);
    req[0] = 1'b0;
    checks++;
    if (!ok || busy !== 1'b1 || write !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: got ok=%b busy=%b write=%b, required 1 1 1", ok, busy, write);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || write !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL single_hold: got busy=%b write=%b gnt=%b, required 1 0 0000", busy, write, gnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || Student_No !== 32'd201819186 || Seat_No !== 5'd1 || Seat_State !== 2'd2) begin
      errors++;
      $display("FAIL single_idle: got busy=%b stu=%0d seat=%0d st=%0d, required 0 201819186 1 2",
               busy, Student_No, Seat_No, Seat_State);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_config_priority;
    bit ok;
    int at_cfg;
    int at_k;
    cfg_req = 1'b1; cfg_sel = 2'd1; cfg_ban = 2'd0;
    drive_kiosk(2, 32'd555001, 5'd17, 2'd1);
    push_cfg(2'd1, 2'd0, 11'd0);
    push_kiosk(2, 32'd555001, 5'd17, 2'd1);
    wait_pulse(-1, ok, at_cfg);
    cfg_req = 1'b0;
    checks++;
    if (!ok || gnt !== '0 || write_set !== 2'd1 || ban !== 2'd0) begin
      errors++;
      $display("FAIL cfg_first: got ok=%b gnt=%b write_set=%0d ban=%0d, required 1 0000 1 0", ok, gnt, write_set, ban);
    end
    wait_pulse(2, ok, at_k);
    req[2] = 1'b0;
    checks++;
    if (!ok || at_k - at_cfg != 3) begin
      errors++;
      $display("FAIL kiosk_after_cfg: got ok=%b delay=%0d, required 1 3", ok, at_k - at_cfg);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_limit;
    bit ok;
    int at;
    cfg_req = 1'b1; cfg_sel = 2'd2; cfg_limit = 11'd15;
    push_cfg(2'd2, 2'd0, 11'd15);
    wait_pulse(-1, ok, at);
    cfg_req = 1'b0;
    checks++;
    if (!ok || write_set !== 2'd2 || limit_time !== 11'd15) begin
      errors++;
      $display("FAIL limit_set: got ok=%b write_set=%0d limit=%0d, required 1 2 15", ok, write_set, limit_time);
    end
    repeat (2) @(negedge clk);
    cfg_req = 1'b1; cfg_sel = 2'd3; cfg_limit = 11'd20; cfg_ban = 2'd3;
    push_cfg(2'd3, 2'd3, 11'd20);
    wait_pulse(-1, ok, at);
    cfg_req = 1'b0;
    checks++;
    if (!ok || write_set !== 2'd0 || limit_time !== 11'd15 || ban !== 2'd0) begin
      errors++;
      $display("FAIL invalid_sel: got ok=%b write_set=%0d limit=%0d ban=%0d, required 1 0 15 0",
               ok, write_set, limit_time, ban);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reject;
    bit ok;
    int at;
    drive_kiosk(1, 32'd777777, 5'd30, 2'd3);
    push_kiosk(1, 32'd777777, 5'd30, 2'd3);
    wait_pulse(1, ok, at);
    req[1] = 1'b0;
    checks++;
    if (!ok || gnt !== 4'b0010 || rej !== 1'b1 || write !== 1'b0 || Student_No !== 32'd555001) begin
      errors++;
      $display("FAIL reject: got ok=%b gnt=%b rej=%b write=%b stu=%0d, required 1 0010 1 0 555001",
               ok, gnt, rej, write, Student_No);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_issue;
    bit ok;
    int at;
    drive_kiosk(2, 32'd424242, 5'd9, 2'd0);
    push_kiosk(2, 32'd424242, 5'd9, 2'd0);
    wait_pulse(2, ok, at);
    checks++;
    if (!ok || write !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_issue: got ok=%b write=%b, required 1 1", ok, write);
    end
    #2;
    rst = 1'b1;
    drive_kiosk(3, 32'd313131, 5'd22, 2'd1);
    #1;
    checks++;
    if ({write, write_set, gnt, rej, cfg_ack, busy, Student_No, Seat_No, Seat_State, ban, limit_time} !==
        {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 2'd2, 11'd10}) begin
      errors++;
      $display("FAIL async_reset: got wr=%b gnt=%b busy=%b stu=%0d ban=%0d lim=%0d, required 0 0000 0 0 2 10",
               write, gnt, busy, Student_No, ban, limit_time);
    end
    m_stu = '0; m_seat = '0; m_st = '0; m_ban = 2'd2; m_lim = 11'd10;
    // With ptr back at 0 the still-pending kiosk 2 must win over kiosk 3.
    push_kiosk(2, 32'd424242, 5'd9, 2'd0);
    push_kiosk(3, 32'd313131, 5'd22, 2'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pulse(2, ok, at);
    req[2] = 1'b0;
    checks++;
    if (!ok || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL reserve_after_reset: got ok=%b gnt=%b, required 1 0100", ok, gnt);
    end
    wait_pulse(3, ok, at);
    req[3] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL second_after_reset: got no grant to kiosk 3, required grant");
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_config_priority();
    test_limit();
    test_reject();
    test_reset_mid_issue();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
